// File: rtl/ex_cpzero_queue_pkg.sv
// ex_cpzero_queue_pkg: shared ALU op encodings and CP0 address packing for the EX-stage CP0 write queue.
package ex_cpzero_queue_pkg;
  localparam logic [7:0] EXE_MTC0_OP = 8'b0110_0000;
  localparam logic [7:0] EXE_MFC0_OP = 8'b0101_1101;
  localparam int CP0_ADDR_W = 8;
  function automatic logic [CP0_ADDR_W-1:0] cp0_addr(input logic [31:0] inst);
    return {inst[15:11], inst[2:0]};
  endfunction
endpackage

// File: rtl/ex_cpzero_queue_fwd_sel.sv
// cp0_fwd_sel: picks the youngest valid entry whose address matches; inputs are age-ordered, index 0 oldest.
module cp0_fwd_sel #(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 8,
  parameter int DATA_W = 32
) (
  input  logic                           en_i,
  input  logic [ADDR_W-1:0]              addr_i,
  input  logic [DEPTH-1:0]               vld_i,
  input  logic [DEPTH-1:0][ADDR_W-1:0]   addr_age_i,
  input  logic [DEPTH-1:0][DATA_W-1:0]   data_age_i,
  output logic                           hit_o,
  output logic [DATA_W-1:0]              data_o
);
  logic [DEPTH-1:0] match;
  for (genvar k = 0; k < DEPTH; k++) begin : g_match
    assign match[k] = en_i & vld_i[k] & (addr_age_i[k] == addr_i);
  end
  // later (younger) matches overwrite earlier ones
  always_comb begin
    hit_o  = 1'b0;
    data_o = '0;
    for (int k = 0; k < DEPTH; k++) begin
      if (match[k]) begin
        hit_o  = 1'b1;
        data_o = data_age_i[k];
      end
    end
  end
endmodule

// File: rtl/ex_cpzero_queue.sv
// ex_cpzero_queue: FIFO of pending MTC0 writes with youngest-match forwarding to MFC0 reads.
module ex_cpzero_queue
  import ex_cpzero_queue_pkg::*;
#(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 8,
  parameter int DATA_W = 32,
  localparam int CW    = $clog2(DEPTH + 1),
  localparam int PW    = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              valid_i,
  input  logic [7:0]        alu_op_i,
  input  logic [31:0]       inst_i,
  input  logic [DATA_W-1:0] reg1_i,
  input  logic              commit_i,
  input  logic              flush_i,
  input  logic [DATA_W-1:0] cp0_rdata_i,
  output logic [ADDR_W-1:0] cp0_raddr_o,
  output logic [DATA_W-1:0] mfc0_data_o,
  output logic              cp0_we_o,
  output logic [ADDR_W-1:0] cp0_waddr_o,
  output logic [DATA_W-1:0] cp0_wdata_o,
  output logic              stall_o,
  output logic [CW-1:0]     count_o
);
  logic [PW-1:0]     head_q, head_d, tail_q, tail_d;
  logic [CW-1:0]     count_q, count_d;
  logic [DEPTH-1:0]  vld_q, vld_d;
  logic [ADDR_W-1:0] addr_mem_q [DEPTH];
  logic [DATA_W-1:0] data_mem_q [DEPTH];
  logic is_mtc0, is_mfc0, nonempty, enq, deq, hit;
  logic [ADDR_W-1:0] inst_addr;
  logic [DATA_W-1:0] fwd_data;
  logic [DEPTH-1:0]  vld_age;
  logic [DEPTH-1:0][ADDR_W-1:0] addr_age;
  logic [DEPTH-1:0][DATA_W-1:0] data_age;
  logic unused_inst;

  assign unused_inst = ^{inst_i[31:16], inst_i[10:3]};
  assign inst_addr   = ADDR_W'(cp0_addr(inst_i));
  assign is_mtc0     = valid_i & (alu_op_i == EXE_MTC0_OP);
  assign is_mfc0     = valid_i & (alu_op_i == EXE_MFC0_OP);
  assign nonempty    = count_q != '0;
  assign stall_o     = is_mtc0 & (count_q == CW'(DEPTH)) & ~(commit_i & ~flush_i);
  assign enq         = is_mtc0 & ~stall_o & ~flush_i;
  assign deq         = commit_i & nonempty & ~flush_i;

  assign cp0_we_o    = deq;
  assign cp0_waddr_o = nonempty ? addr_mem_q[head_q] : '0;
  assign cp0_wdata_o = nonempty ? data_mem_q[head_q] : '0;
  assign count_o     = count_q;
  // reads are gated by rst because they are otherwise pure functions of the inputs
  assign cp0_raddr_o = (is_mfc0 & ~rst) ? inst_addr : '0;
  assign mfc0_data_o = rst ? '0 : hit ? fwd_data : cp0_rdata_i;

  always_comb begin
    for (int k = 0; k < DEPTH; k++) begin
      vld_age[k]  = vld_q[head_q + PW'(k)];
      addr_age[k] = addr_mem_q[head_q + PW'(k)];
      data_age[k] = data_mem_q[head_q + PW'(k)];
    end
  end

  cp0_fwd_sel #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_fwd (
    .en_i       (is_mfc0 & ~flush_i),
    .addr_i     (inst_addr),
    .vld_i      (vld_age),
    .addr_age_i (addr_age),
    .data_age_i (data_age),
    .hit_o      (hit),
    .data_o     (fwd_data)
  );

  // enqueue applied after dequeue so a full-queue swap on the same slot keeps it valid
  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    vld_d   = vld_q;
    count_d = count_q;
    if (flush_i) begin
      head_d  = '0;
      tail_d  = '0;
      vld_d   = '0;
      count_d = '0;
    end else begin
      if (deq) begin
        vld_d[head_q] = 1'b0;
        head_d        = head_q + 1'b1;
      end
      if (enq) begin
        vld_d[tail_q] = 1'b1;
        tail_d        = tail_q + 1'b1;
      end
      count_d = count_q + CW'(enq) - CW'(deq);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      vld_q   <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      vld_q   <= vld_d;
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (enq) begin
      addr_mem_q[tail_q] <= inst_addr;
      data_mem_q[tail_q] <= reg1_i;
    end
  end
endmodule

// File: tb/tb_ex_cpzero_queue.sv
// tb_ex_cpzero_queue: table-driven directed vectors plus reset and wrap-around sequences.
module tb_ex_cpzero_queue;
  import ex_cpzero_queue_pkg::*;
  localparam logic [7:0] MT = EXE_MTC0_OP, MF = EXE_MFC0_OP, NP = 8'h21;

  logic clk = 1'b0, rst, valid_i, commit_i, flush_i;
  logic [7:0] alu_op_i, cp0_raddr_o, cp0_waddr_o;
  logic [31:0] inst_i, reg1_i, cp0_rdata_i, mfc0_data_o, cp0_wdata_o;
  logic cp0_we_o, stall_o;
  logic [2:0] count_o;
  int checks = 0, fails = 0;

  always #5 clk = ~clk;

  ex_cpzero_queue dut (
    .clk(clk), .rst(rst), .valid_i(valid_i), .alu_op_i(alu_op_i), .inst_i(inst_i),
    .reg1_i(reg1_i), .commit_i(commit_i), .flush_i(flush_i), .cp0_rdata_i(cp0_rdata_i),
    .cp0_raddr_o(cp0_raddr_o), .mfc0_data_o(mfc0_data_o), .cp0_we_o(cp0_we_o),
    .cp0_waddr_o(cp0_waddr_o), .cp0_wdata_o(cp0_wdata_o), .stall_o(stall_o), .count_o(count_o)
  );

  typedef struct {
    logic v; logic [7:0] op; logic [4:0] rd; logic [2:0] sel; logic [31:0] d;
    logic c; logic f; logic [31:0] rdata;
    logic we; logic [7:0] wa; logic [31:0] wd; logic [7:0] ra; logic [31:0] mf; logic st; logic [2:0] cnt;
  } vec_t;
  vec_t vecs[$];

  function automatic vec_t mk(logic v, logic [7:0] op, logic [4:0] rd, logic [2:0] sel, logic [31:0] d,
      logic c, logic f, logic [31:0] rdata, logic we, logic [7:0] wa, logic [31:0] wd,
      logic [7:0] ra, logic [31:0] mf, logic st, logic [2:0] cnt);
    vec_t r;
    r.v = v; r.op = op; r.rd = rd; r.sel = sel; r.d = d; r.c = c; r.f = f; r.rdata = rdata;
    r.we = we; r.wa = wa; r.wd = wd; r.ra = ra; r.mf = mf; r.st = st; r.cnt = cnt;
    return r;
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(logic v, logic [7:0] op, logic [4:0] rd, logic [2:0] sel, logic [31:0] d,
      logic c, logic f, logic [31:0] rdata);
    valid_i = v; alu_op_i = op; inst_i = {16'h0, rd, 8'h0, sel}; reg1_i = d;
    commit_i = c; flush_i = f; cp0_rdata_i = rdata;
  endtask

  task automatic check_outs(string tag, logic we, logic [7:0] wa, logic [31:0] wd, logic [7:0] ra,
      logic [31:0] mf, logic st, logic [2:0] cnt);
    chk({tag, ".we"}, 32'(cp0_we_o), 32'(we));
    chk({tag, ".waddr"}, 32'(cp0_waddr_o), 32'(wa));
    chk({tag, ".wdata"}, cp0_wdata_o, wd);
    chk({tag, ".raddr"}, 32'(cp0_raddr_o), 32'(ra));
    chk({tag, ".mfc0"}, mfc0_data_o, mf);
    chk({tag, ".stall"}, 32'(stall_o), 32'(st));
    chk({tag, ".count"}, 32'(count_o), 32'(cnt));
  endtask

  initial begin
    vecs.push_back(mk(0, NP,  0, 0, 0,      0, 0, 0,     0, 8'h00, 0,      8'h00, 0,     0, 0));
    vecs.push_back(mk(1, MT, 12, 0, 'hFF01, 0, 0, 0,     0, 8'h00, 0,      8'h00, 0,     0, 0));
    vecs.push_back(mk(0, NP,  0, 0, 0,      1, 0, 0,     1, 8'h60, 'hFF01, 8'h00, 0,     0, 1));
    vecs.push_back(mk(0, NP,  0, 0, 0,      0, 0, 0,     0, 8'h00, 0,      8'h00, 0,     0, 0));
    vecs.push_back(mk(1, MT, 11, 0, 'hA,    0, 0, 0,     0, 8'h00, 0,      8'h00, 0,     0, 0));
    vecs.push_back(mk(1, MT, 11, 0, 'hB,    0, 0, 0,     0, 8'h58, 'hA,    8'h00, 0,     0, 1));
    vecs.push_back(mk(1, MF, 11, 0, 0,      0, 0, 5,     0, 8'h58, 'hA,    8'h58, 'hB,   0, 2));
    vecs.push_back(mk(1, MF, 11, 0, 0,      1, 0, 5,     1, 8'h58, 'hA,    8'h58, 'hB,   0, 2));
    vecs.push_back(mk(1, MF, 11, 0, 0,      1, 0, 5,     1, 8'h58, 'hB,    8'h58, 'hB,   0, 1));
    vecs.push_back(mk(1, MF, 11, 0, 0,      0, 0, 5,     0, 8'h00, 0,      8'h58, 5,     0, 0));
    vecs.push_back(mk(1, MF, 12, 1, 0,      0, 0, 'h77,  0, 8'h00, 0,      8'h61, 'h77,  0, 0));
    vecs.push_back(mk(1, NP,  3, 0, 'h55,   1, 0, 0,     0, 8'h00, 0,      8'h00, 0,     0, 0));
    vecs.push_back(mk(1, MT,  1, 0, 1,      0, 0, 0,     0, 8'h00, 0,      8'h00, 0,     0, 0));
    vecs.push_back(mk(1, MT,  2, 0, 2,      0, 0, 0,     0, 8'h08, 1,      8'h00, 0,     0, 1));
    vecs.push_back(mk(1, MT,  3, 0, 3,      0, 0, 0,     0, 8'h08, 1,      8'h00, 0,     0, 2));
    vecs.push_back(mk(1, MT,  4, 0, 4,      0, 0, 0,     0, 8'h08, 1,      8'h00, 0,     0, 3));
    vecs.push_back(mk(1, MT,  5, 0, 5,      0, 0, 0,     0, 8'h08, 1,      8'h00, 0,     1, 4));
    vecs.push_back(mk(1, MT,  5, 0, 5,      1, 0, 0,     1, 8'h08, 1,      8'h00, 0,     0, 4));
    vecs.push_back(mk(0, NP,  0, 0, 0,      0, 0, 0,     0, 8'h10, 2,      8'h00, 0,     0, 4));
    vecs.push_back(mk(0, NP,  0, 0, 0,      1, 0, 0,     1, 8'h10, 2,      8'h00, 0,     0, 4));
    vecs.push_back(mk(1, MF,  4, 0, 0,      0, 0, 'h99,  0, 8'h18, 3,      8'h20, 4,     0, 3));
    vecs.push_back(mk(1, MF,  4, 0, 0,      1, 1, 'h99,  0, 8'h18, 3,      8'h20, 'h99,  0, 3));
    vecs.push_back(mk(1, MT,  7, 0, 7,      1, 1, 0,     0, 8'h00, 0,      8'h00, 0,     0, 0));
    vecs.push_back(mk(0, NP,  0, 0, 0,      1, 0, 0,     0, 8'h00, 0,      8'h00, 0,     0, 0));

    rst = 1'b1;
    drive(1, MF, 11, 0, 0, 1, 0, 32'h1234);
    @(negedge clk); #1;
    check_outs("reset", 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    rst = 1'b0;

    foreach (vecs[i]) begin
      @(negedge clk);
      drive(vecs[i].v, vecs[i].op, vecs[i].rd, vecs[i].sel, vecs[i].d, vecs[i].c, vecs[i].f, vecs[i].rdata);
      #1;
      check_outs($sformatf("vec%0d", i), vecs[i].we, vecs[i].wa, vecs[i].wd, vecs[i].ra,
                 vecs[i].mf, vecs[i].st, vecs[i].cnt);
    end

    @(negedge clk); drive(1, MT, 9, 0, 32'h91, 0, 0, 0);
    @(negedge clk); drive(1, MT, 9, 0, 32'h92, 0, 0, 0);
    @(negedge clk); drive(0, NP, 0, 0, 0, 0, 0, 0); #1;
    chk("midrst.pre_count", 32'(count_o), 2);
    drive(1, MF, 9, 0, 0, 1, 0, 32'h5);
    rst = 1'b1; #1;
    check_outs("midrst", 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk); rst = 1'b0; drive(0, NP, 0, 0, 0, 1, 0, 0);
    for (int k = 0; k < 2; k++) begin
      #1;
      chk($sformatf("postrst%0d.we", k), 32'(cp0_we_o), 0);
      chk($sformatf("postrst%0d.count", k), 32'(count_o), 0);
      @(negedge clk);
    end

    drive(1, MT, 1, 0, 1, 0, 0, 0);
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      if (k < 10) drive(1, MT, 5'(k + 1), 0, 32'(k + 1), 1, 0, 0);
      else drive(0, NP, 0, 0, 0, 1, 0, 0);
      #1;
      chk($sformatf("wrap%0d.we", k), 32'(cp0_we_o), 1);
      chk($sformatf("wrap%0d.waddr", k), 32'(cp0_waddr_o), 32'(k) << 3);
      chk($sformatf("wrap%0d.wdata", k), cp0_wdata_o, 32'(k));
      chk($sformatf("wrap%0d.count", k), 32'(count_o), 1);
    end
    @(negedge clk); drive(0, NP, 0, 0, 0, 0, 0, 0); #1;
    chk("wrap.final_count", 32'(count_o), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
